inst_mem_arbiter: RTL and testbench
===================================

Name: inst_mem_arbiter

Overview:
- Owns the single port of the instruction BRAM and shares it between three requesters: the fetch unit (reads), the program loader (UART boot writes) and the debug/monitor reader.
- Sequences the core's boot: LOAD phase (loader fills memory) -> RUN (fetch owns the port) -> optional reload via DRAIN.
- Sits between fetch/loader/debug and the instruction BRAM; drives the core-start signal.

Parameters:
- ADDR_W, 17, word-address width of instruction memory
- DATA_W, 32, instruction word width
- STARVE_MAX, 15, max consecutive cycles a pending debug read may lose to fetch before it is forced through

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch wants a read this cycle
- fetch_addr  in  ADDR_W  fetch word address
- fetch_grant  out  1  fetch read issued this cycle (comb)
- fetch_rvalid  out  1  fetch read data valid (cycle after grant)
- fetch_rdata  out  DATA_W  fetch read data
- ld_req  in  1  loader write request, held until ld_ack
- ld_addr  in  ADDR_W  loader write address
- ld_wdata  in  DATA_W  loader write data
- ld_last  in  1  qualifies ld_req: final word of image
- ld_ack  out  1  write issued this cycle (comb)
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  ADDR_W  debug read address
- dbg_ack  out  1  debug data valid (cycle after grant)
- dbg_rdata  out  DATA_W  debug read data
- reload  in  1  pulse: return to LOAD
- mem_en  out  1  BRAM enable (comb)
- mem_we  out  1  BRAM write enable (comb)
- mem_addr  out  ADDR_W  BRAM address (comb)
- mem_wdata  out  DATA_W  BRAM write data (comb)
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency
- run  out  1  core may execute (state==RUN)
- load_count  out  ADDR_W+1  words written since entering LOAD, saturating

Behaviour:
- Reset (async, rstn=0): state=LOAD, run=0, load_count=0, starve counter=0, return tag=NONE, dbg busy=0; fetch_rvalid=0, dbg_ack=0, fetch_rdata/dbg_rdata follow mem_rdata (don't-care); all comb grants 0 while rstn=0. Reset mid-read discards the outstanding read; no rvalid/ack after release.
- At most one grant per cycle; mem_* reflect the granted requester combinationally; mem_en=0 when none.
- Return path: registered tag (FETCH/DBG/NONE) set on grant edge. Next cycle: fetch_rvalid or dbg_ack = 1 for exactly one cycle; rdata = mem_rdata passthrough.
- Writes complete at the grant edge; no return cycle.
- LOAD: priority ld > dbg. fetch_grant=0. ld_ack=ld_req. Each accepted write increments load_count (saturate at 2^ADDR_W). Accepted write with ld_last -> RUN next cycle.
- RUN: ld_req ignored (ld_ack=0). Priority fetch > dbg, except when starve==STARVE_MAX and dbg pending: dbg wins, fetch_grant=0 that cycle (fetch must hold its address and re-request).
- Starve counter: increments each cycle dbg pending and not granted. Saturates at STARVE_MAX. Clears on dbg grant or on leaving RUN.
- Debug handshake: dbg_req is ignored in the dbg_ack cycle (busy flag), so no double grant. Requester drops or re-raises after ack.
- reload in RUN -> DRAIN. In DRAIN: no new grants. Outstanding return still delivered. Next cycle -> LOAD with load_count=0 and run=0. reload in LOAD/DRAIN ignored.
- run deasserts in the same edge that enters DRAIN.

Test Plan:
- Boot: write addrs 0..3 with data 0xA0..0xA3, ld_last on addr 3 -> ld_ack 4 cycles; load_count=4; run=1 the cycle after the last ack; fetch_grant=0 throughout LOAD.
- RUN fetch stream: fetch_req=1, addrs 0,1,2 on consecutive cycles -> fetch_rvalid 1 cycle later each, rdata 0xA0,0xA1,0xA2; mem_we=0.
- Debug starvation: fetch_req held 1, dbg_req=1 addr 2 -> dbg granted on the 16th cycle (counter 0..15). fetch_grant=0 in that cycle. dbg_ack next cycle with 0xA2. Counter back to 0.
- Debug in idle gap: fetch_req=0, dbg_req addr 1 -> grant same cycle; dbg_ack next cycle, 0xA1. dbg_req held through the ack cycle -> no second grant in that cycle.
- Reload with fetch in flight: grant fetch addr 3, reload same cycle -> fetch_rvalid next cycle (0xA3), run=0. LOAD after DRAIN with load_count=0. ld_req in RUN beforehand never acked.
- Async reset mid-read: drop rstn between grant and return -> no fetch_rvalid. State LOAD, run=0 immediately.

Source files
------------

// File: rtl/inst_mem_arbiter.sv
// Instruction memory arbiter: shares the single instruction BRAM port
// between the boot loader (writes), instruction fetch and the debug
// reader (reads). It also sequences boot: LOAD -> RUN -> DRAIN -> LOAD.
module inst_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rstn,
    // fetch unit
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    // program loader
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_last,
    output logic              ld_ack,
    // debug reader
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    // control
    input  logic              reload,
    // instruction BRAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              run,
    output logic [ADDR_W:0]   load_count
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_W:0] LOAD_MAX   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DBG   = 2'd2
    } tag_t;

    state_t          state_reg, state_next;
    tag_t            tag_reg;
    logic [SW-1:0]   starve_reg;
    logic [ADDR_W:0] load_count_reg;
    logic            dbg_busy_reg;

    logic ld_grant;
    logic dbg_grant;
    logic dbg_pending;
    logic starve_force;

    // A debug request still waiting in its ack cycle must not be granted again
    assign dbg_pending  = dbg_req & ~dbg_busy_reg;
    assign starve_force = dbg_pending && (starve_reg == STARVE_LIM);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: last loader word starts the core, reload drains back to LOAD
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:  if (ld_grant && ld_last) state_next = ST_RUN;
            ST_RUN:   if (reload) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_LOAD;
            default:  state_next = ST_LOAD;
        endcase
    end

    // Grant selection: one requester per cycle, nothing while in reset or DRAIN
    always_comb begin
        fetch_grant = 1'b0;
        ld_grant    = 1'b0;
        dbg_grant   = 1'b0;
        if (rstn) begin
            case (state_reg)
                ST_LOAD: begin
                    ld_grant  = ld_req;
                    dbg_grant = dbg_pending & ~ld_req;
                end
                ST_RUN: begin
                    // fetch normally wins; a starved debug read is forced through
                    fetch_grant = fetch_req & ~starve_force;
                    dbg_grant   = dbg_pending & (starve_force | ~fetch_req);
                end
                default: ;
            endcase
        end
    end

    // BRAM port mux follows whichever requester holds the grant
    always_comb begin
        mem_en    = fetch_grant | ld_grant | dbg_grant;
        mem_we    = ld_grant;
        mem_wdata = ld_grant ? ld_wdata : '0;
        if (ld_grant) begin
            mem_addr = ld_addr;
        end else if (dbg_grant) begin
            mem_addr = dbg_addr;
        end else if (fetch_grant) begin
            mem_addr = fetch_addr;
        end else begin
            mem_addr = '0;
        end
    end

    // Return-path tag and debug busy flag, captured on the grant edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_reg      <= TAG_NONE;
            dbg_busy_reg <= 1'b0;
        end else begin
            dbg_busy_reg <= dbg_grant;
            if (fetch_grant) begin
                tag_reg <= TAG_FETCH;
            end else if (dbg_grant) begin
                tag_reg <= TAG_DBG;
            end else begin
                tag_reg <= TAG_NONE;
            end
        end
    end

    // Starvation counter: counts lost debug cycles in RUN, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_reg <= '0;
        end else if (state_next != ST_RUN || dbg_grant) begin
            starve_reg <= '0;
        end else if (dbg_pending && starve_reg != STARVE_LIM) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

    // Loader word counter, cleared while draining so LOAD starts from zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_count_reg <= '0;
        end else if (state_reg == ST_DRAIN) begin
            load_count_reg <= '0;
        end else if (ld_grant && load_count_reg != LOAD_MAX) begin
            load_count_reg <= load_count_reg + 1'b1;
        end
    end

    // Outputs derived from registered state
    always_comb begin
        ld_ack       = ld_grant;
        fetch_rvalid = (tag_reg == TAG_FETCH);
        dbg_ack      = (tag_reg == TAG_DBG);
        fetch_rdata  = mem_rdata;
        dbg_rdata    = mem_rdata;
        run          = (state_reg == ST_RUN);
        load_count   = load_count_reg;
    end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Testbench for inst_mem_arbiter: behavioural BRAM, read-data scoreboard,
// boot / fetch / starvation / idle debug / reload / reset scenarios.
module tb_inst_mem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_grant;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_last;
    logic              ld_ack;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              reload;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              run;
    logic [ADDR_W:0]   load_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bram    [0:15];
    logic [DATA_W-1:0] ref_mem [0:15];
    logic [DATA_W-1:0] fetch_q [$];
    logic [DATA_W-1:0] dbg_q   [$];

    always #5 clk = ~clk;

    inst_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(15)) dut (
        .clk(clk), .rstn(rstn),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_last(ld_last),
        .ld_ack(ld_ack),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .reload(reload),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .run(run), .load_count(load_count)
    );

    // Behavioural single-port BRAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[3:0]] <= mem_wdata;
            mem_rdata <= bram[mem_addr[3:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: returns are popped before this cycle's grant is pushed
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (fetch_rvalid) begin
                if (fetch_q.size() == 0) check("fetch_unexpected_rvalid", 1, 0);
                else check("fetch_rdata", fetch_rdata, fetch_q.pop_front());
            end
            if (dbg_ack) begin
                if (dbg_q.size() == 0) check("dbg_unexpected_ack", 1, 0);
                else check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
            if (fetch_grant) fetch_q.push_back(ref_mem[fetch_addr[3:0]]);
        end
    end

    // Hold fetch busy on address 0 and measure how long a debug read waits
    task automatic starve_run(input logic [3:0] a, input string tag);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = '0;
        dbg_req    = 1'b1;
        dbg_addr   = ADDR_W'(a);
        dbg_q.push_back(ref_mem[a]);
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (!fetch_grant) begin
                got = 1'b1;
                n   = c;
                check({tag, "_grant_addr"}, mem_addr, ADDR_W'(a));
                check({tag, "_grant_en"}, mem_en, 1);
            end
            next_cycle();
        end
        check({tag, "_grant_cycle"}, n, 16);
        // dbg_req still held in the ack cycle: fetch must win, no regrant
        @(negedge clk);
        check({tag, "_ack"}, dbg_ack, 1);
        check({tag, "_busy_fetch_wins"}, fetch_grant, 1);
        next_cycle();
        dbg_req   = 1'b0;
        fetch_req = 1'b0;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_rdata  = '0;
        rstn       = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b1;
        ld_addr    = '0;
        ld_wdata   = '0;
        ld_last    = 1'b0;
        dbg_req    = 1'b0;
        dbg_addr   = '0;
        reload     = 1'b0;

        // Reset state: no grants even with a request present
        @(negedge clk);
        check("rst_run", run, 0);
        check("rst_load_count", load_count, 0);
        check("rst_ld_ack", ld_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_fetch_rvalid", fetch_rvalid, 0);
        next_cycle();
        rstn   = 1'b1;
        ld_req = 1'b0;
        next_cycle();

        // Boot: four loader writes, fetch requests ignored in LOAD
        for (int i = 0; i < 4; i++) begin
            ld_req     = 1'b1;
            ld_addr    = ADDR_W'(i);
            ld_wdata   = 32'hA0 + 32'(i);
            ld_last    = (i == 3);
            fetch_req  = 1'b1;
            ref_mem[i] = 32'hA0 + 32'(i);
            @(negedge clk);
            check("boot_ld_ack", ld_ack, 1);
            check("boot_mem_we", mem_we, 1);
            check("boot_fetch_grant", fetch_grant, 0);
            check("boot_load_count", load_count, 64'(i));
            check("boot_run", run, 0);
            next_cycle();
        end
        ld_req    = 1'b0;
        ld_last   = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        check("boot_run_after_last", run, 1);
        check("boot_load_count_final", load_count, 4);
        next_cycle();

        // RUN fetch stream with a stray loader request that must be ignored
        for (int a = 0; a < 3; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(a);
            ld_req     = 1'b1;
            ld_addr    = 17'd5;
            ld_wdata   = 32'hDEAD;
            @(negedge clk);
            check("run_fetch_grant", fetch_grant, 1);
            check("run_mem_we", mem_we, 0);
            check("run_ld_ack", ld_ack, 0);
            check("run_mem_addr", mem_addr, 64'(a));
            next_cycle();
        end
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        next_cycle();
        next_cycle();

        // Starvation, twice: second run shows the counter restarted from 0
        starve_run(4'd2, "starve1");
        starve_run(4'd3, "starve2");

        // Debug read in an idle gap, request held through the ack cycle
        dbg_req  = 1'b1;
        dbg_addr = 17'd1;
        dbg_q.push_back(ref_mem[1]);
        @(negedge clk);
        check("idle_dbg_en", mem_en, 1);
        check("idle_dbg_addr", mem_addr, 1);
        next_cycle();
        @(negedge clk);
        check("idle_dbg_ack", dbg_ack, 1);
        check("idle_no_regrant", mem_en, 0);
        next_cycle();
        dbg_req = 1'b0;
        next_cycle();

        // Reload with a fetch in flight
        fetch_req  = 1'b1;
        fetch_addr = 17'd3;
        reload     = 1'b1;
        @(negedge clk);
        check("reload_fetch_grant", fetch_grant, 1);
        next_cycle();
        fetch_req = 1'b0;
        reload    = 1'b0;
        @(negedge clk);
        check("drain_run", run, 0);
        check("drain_fetch_rvalid", fetch_rvalid, 1);
        check("drain_no_grant", mem_en, 0);
        next_cycle();
        ld_req     = 1'b1;
        ld_addr    = '0;
        ld_wdata   = 32'hB0;
        ld_last    = 1'b1;
        ref_mem[0] = 32'hB0;
        @(negedge clk);
        check("reload_load_count", load_count, 0);
        check("reload_run", run, 0);
        check("reload_ld_ack", ld_ack, 1);
        next_cycle();
        ld_req  = 1'b0;
        ld_last = 1'b0;
        @(negedge clk);
        check("reload_run_again", run, 1);
        check("reload_load_count_1", load_count, 1);
        next_cycle();

        // Async reset between grant and return discards the read
        fetch_req  = 1'b1;
        fetch_addr = '0;
        @(negedge clk);
        check("rstmid_fetch_grant", fetch_grant, 1);
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        fetch_req = 1'b0;
        #1;
        fetch_q.delete();
        check("rstmid_rvalid_now", fetch_rvalid, 0);
        check("rstmid_run_now", run, 0);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("rstmid_rvalid_after", fetch_rvalid, 0);
        check("rstmid_load_count", load_count, 0);
        check("rstmid_run_after", run, 0);
        next_cycle();
        next_cycle();

        check("fetch_q_empty", fetch_q.size(), 0);
        check("dbg_q_empty", dbg_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
